// File: rtl/layer_mux_pkg.sv
// Shared types and helpers for the layer priority mux: index width, per-layer
// config entry and the reset/default table contents.
package layer_mux_pkg;

  localparam int MAX_IDX_W = 5;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] rank;
    logic                 enable;
    logic                 blink;
  } layer_cfg_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Identity ranking reproduces the old fixed-order mux.
  function automatic layer_cfg_t default_cfg(input int i);
    layer_cfg_t c;
    c.rank   = MAX_IDX_W'(i);
    c.enable = 1'b1;
    c.blink  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/layer_rank_arbiter.sv
// Combinational min-rank selection over the effective request vector.
// Strict less-than keeps the lower layer index on equal ranks.
module layer_rank_arbiter
  import layer_mux_pkg::*;
#(
  parameter  int NUM_LAYERS = 16,
  localparam int IDX_W      = idx_w(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]           eff,
  input  logic [NUM_LAYERS*MAX_IDX_W-1:0] ranks,
  output logic [IDX_W-1:0]                win_idx,
  output logic                            win_valid
);

  logic [MAX_IDX_W-1:0] best_rank;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    best_rank = '1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (eff[i] && (!win_valid || (ranks[i*MAX_IDX_W +: MAX_IDX_W] < best_rank))) begin
        win_valid = 1'b1;
        best_rank = ranks[i*MAX_IDX_W +: MAX_IDX_W];
        win_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/layer_priority_mux.sv
// Two-stage pixel mux choosing the lowest-rank enabled layer, with shadowed
// rank table committed at frame start. Optional LAYER_MUX_COLLISION_EN adds collision flags.
module layer_priority_mux
  import layer_mux_pkg::*;
#(
  parameter  int NUM_LAYERS   = 16,
  parameter  int RGB_W        = 8,
  parameter  int BLINK_FRAMES = 15,
  localparam int IDX_W        = idx_w(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            bgRGB,
  input  logic                        cfgValid,
  output logic                        cfgReady,
  input  logic [IDX_W-1:0]            cfgLayer,
  input  logic [IDX_W-1:0]            cfgRank,
  input  logic                        cfgEnable,
  input  logic                        cfgBlink,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [IDX_W-1:0]            topLayer,
  output logic                        topValid,
  output logic [NUM_LAYERS-1:0]       collisionFlags
);

  layer_cfg_t active_tbl [NUM_LAYERS];
  layer_cfg_t shadow_tbl [NUM_LAYERS];
  layer_cfg_t cfg_new;
  logic [7:0] frame_cnt, frame_cnt_next;
  logic       phase, phase_next;
  logic       cfg_wr;

  // Handshake: a config write transfers on any clk edge where cfgValid && cfgReady;
  // cfgReady drops only in the startOfFrame cycle so commit and write never coincide.
  assign cfgReady = ~startOfFrame;
  assign cfg_wr   = cfgValid && cfgReady && (int'(cfgLayer) < NUM_LAYERS);

  always_comb begin
    cfg_new        = '0;
    cfg_new.rank   = MAX_IDX_W'(cfgRank);
    cfg_new.enable = cfgEnable;
    cfg_new.blink  = cfgBlink;
  end

  always_comb begin
    frame_cnt_next = frame_cnt;
    phase_next     = phase;
    if (startOfFrame) begin
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_next = '0;
        phase_next     = ~phase;
      end else begin
        frame_cnt_next = frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        active_tbl[i] <= default_cfg(i);
        shadow_tbl[i] <= default_cfg(i);
      end
    end else begin
      frame_cnt <= frame_cnt_next;
      phase     <= phase_next;
      if (startOfFrame) active_tbl <= shadow_tbl;
      if (cfg_wr) shadow_tbl[cfgLayer] <= cfg_new;
    end
  end

  // The commit-cycle pixel already sees the new table and the new blink phase.
  logic [NUM_LAYERS-1:0] eff;
  layer_cfg_t            sel_cfg;

  always_comb begin
    eff     = '0;
    sel_cfg = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      sel_cfg = startOfFrame ? shadow_tbl[i] : active_tbl[i];
      eff[i]  = drawReq[i] & sel_cfg.enable & ~(sel_cfg.blink & phase_next);
    end
  end

  logic [NUM_LAYERS-1:0] s1_eff;
  logic [RGB_W-1:0]      s1_rgb [NUM_LAYERS];
  logic [RGB_W-1:0]      s1_bg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_eff <= '0;
      s1_bg  <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) s1_rgb[i] <= '0;
    end else begin
      s1_eff <= eff;
      s1_bg  <= bgRGB;
      for (int i = 0; i < NUM_LAYERS; i++) s1_rgb[i] <= layerRGB[i*RGB_W +: RGB_W];
    end
  end

  // Ranks are read from the active table in S2; it flips on the same edge as S1 capture.
  logic [NUM_LAYERS*MAX_IDX_W-1:0] ranks;
  logic [IDX_W-1:0]                win_idx;
  logic                            win_valid;

  always_comb begin
    ranks = '0;
    for (int i = 0; i < NUM_LAYERS; i++) ranks[i*MAX_IDX_W +: MAX_IDX_W] = active_tbl[i].rank;
  end

  layer_rank_arbiter #(.NUM_LAYERS(NUM_LAYERS)) u_arb (
    .eff       (s1_eff),
    .ranks     (ranks),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut   <= '0;
      topLayer <= '0;
      topValid <= 1'b0;
    end else begin
      RGBOut   <= win_valid ? s1_rgb[win_idx] : s1_bg;
      topLayer <= win_valid ? win_idx : '0;
      topValid <= win_valid;
    end
  end

`ifdef LAYER_MUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] acc, hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      hit[i] = eff[i] & (|(eff & ~(NUM_LAYERS'(1) << i)));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc            <= '0;
      collisionFlags <= '0;
    end else if (startOfFrame) begin
      collisionFlags <= acc;
      acc            <= hit;
    end else begin
      acc <= acc | hit;
    end
  end
`else
  assign collisionFlags = '0;
`endif

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux (BLINK_FRAMES=2) with hand-computed expectations.
module tb_layer_priority_mux;

  localparam int NL = 16;
  localparam int RW = 8;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             startOfFrame = 1'b0;
  logic [NL-1:0]    drawReq = '0;
  logic [NL*RW-1:0] layerRGB;
  logic [RW-1:0]    bgRGB = 8'h5A;
  logic             cfgValid = 1'b0;
  logic             cfgReady;
  logic [IW-1:0]    cfgLayer = '0;
  logic [IW-1:0]    cfgRank = '0;
  logic             cfgEnable = 1'b0;
  logic             cfgBlink = 1'b0;
  logic [RW-1:0]    RGBOut;
  logic [IW-1:0]    topLayer;
  logic             topValid;
  logic [NL-1:0]    collisionFlags;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  layer_priority_mux #(.NUM_LAYERS(NL), .RGB_W(RW), .BLINK_FRAMES(2)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .drawReq        (drawReq),
    .layerRGB       (layerRGB),
    .bgRGB          (bgRGB),
    .cfgValid       (cfgValid),
    .cfgReady       (cfgReady),
    .cfgLayer       (cfgLayer),
    .cfgRank        (cfgRank),
    .cfgEnable      (cfgEnable),
    .cfgBlink       (cfgBlink),
    .RGBOut         (RGBOut),
    .topLayer       (topLayer),
    .topValid       (topValid),
    .collisionFlags (collisionFlags)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] color(input int idx);
    return 8'(8'h31 + 7 * idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic cfg_write(input int layer, input int rank, input logic en, input logic bl);
    @(negedge clk);
    cfgLayer  = IW'(layer);
    cfgRank   = IW'(rank);
    cfgEnable = en;
    cfgBlink  = bl;
    cfgValid  = 1'b1;
    @(negedge clk);
    cfgValid  = 1'b0;
  endtask

  // One pixel (optionally on a startOfFrame cycle), result checked two edges later.
  task automatic run_pixel(input string tag, input logic [NL-1:0] req, input logic sof,
                           input logic exp_valid, input int exp_layer);
    logic [12:0] e;
    exp_q.push_back({exp_valid, exp_valid ? 4'(exp_layer) : 4'd0,
                     exp_valid ? color(exp_layer) : bgRGB});
    @(negedge clk);
    drawReq      = req;
    startOfFrame = sof;
    if (sof) begin
      #1;
      check({tag, "/cfgReady"}, 32'(cfgReady), 32'd0);
    end
    @(negedge clk);
    drawReq      = '0;
    startOfFrame = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "/valid"}, 32'(topValid), 32'(e[12]));
    check({tag, "/layer"}, 32'(topLayer), 32'(e[11:8]));
    check({tag, "/rgb"},   32'(RGBOut),   32'(e[7:0]));
  endtask

  initial begin
    for (int i = 0; i < NL; i++) layerRGB[i*RW +: RW] = color(i);

    // Reset defaults
    repeat (2) @(negedge clk);
    check("rst/rgb",   32'(RGBOut), 32'd0);
    check("rst/layer", 32'(topLayer), 32'd0);
    check("rst/valid", 32'(topValid), 32'd0);
    check("rst/ready", 32'(cfgReady), 32'd1);
    check("rst/coll",  32'(collisionFlags), 32'd0);
    resetN = 1'b1;

    run_pixel("def_05", 16'h0005, 1'b0, 1'b1, 0);
    run_pixel("def_8000", 16'h8000, 1'b0, 1'b1, 15);
    run_pixel("def_ffff", 16'hFFFF, 1'b0, 1'b1, 0);

    // Reprogram: visible only after commit
    cfg_write(2, 0, 1'b1, 1'b0);
    cfg_write(0, 2, 1'b1, 1'b0);
    run_pixel("pre_commit", 16'h0005, 1'b0, 1'b1, 0);
    run_pixel("commit", 16'h0000, 1'b1, 1'b0, 0);
    run_pixel("post_05", 16'h0005, 1'b0, 1'b1, 2);
    run_pixel("post_03", 16'h0003, 1'b0, 1'b1, 1);
    cfg_write(3, 0, 1'b1, 1'b0);
    run_pixel("commit2", 16'h0000, 1'b1, 1'b0, 0);
    run_pixel("tie_0c", 16'h000C, 1'b0, 1'b1, 2);

    // Empty / disable
    run_pixel("empty", 16'h0000, 1'b0, 1'b0, 0);
    cfg_write(3, 3, 1'b0, 1'b0);
    run_pixel("commit3", 16'h0000, 1'b1, 1'b0, 0);
    run_pixel("dis_08", 16'h0008, 1'b0, 1'b0, 0);
    run_pixel("dis_18", 16'h0018, 1'b0, 1'b1, 4);

    // Reset mid-frame clears pipeline and tables
    @(negedge clk);
    drawReq = 16'h0001;
    @(negedge clk);
    drawReq = '0;
    resetN  = 1'b0;
    #1;
    check("midrst/valid", 32'(topValid), 32'd0);
    @(negedge clk);
    check("midrst/rgb", 32'(RGBOut), 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    check("midrst/flush", 32'(topValid), 32'd0);
    run_pixel("midrst_tbl", 16'h0005, 1'b0, 1'b1, 0);

    // Blink with BLINK_FRAMES=2
    do_reset();
    cfg_write(1, 1, 1'b1, 1'b1);
    run_pixel("blink_f0", 16'h0002, 1'b0, 1'b1, 1);
    run_pixel("blink_sof1", 16'h0002, 1'b1, 1'b1, 1);
    run_pixel("blink_f1", 16'h0002, 1'b0, 1'b1, 1);
    run_pixel("blink_sof2", 16'h0002, 1'b1, 1'b0, 0);
    run_pixel("blink_f2", 16'h0006, 1'b0, 1'b1, 2);
    run_pixel("blink_sof3", 16'h0000, 1'b1, 1'b0, 0);
    run_pixel("blink_f3", 16'h0002, 1'b0, 1'b0, 0);
    run_pixel("blink_sof4", 16'h0000, 1'b1, 1'b0, 0);
    run_pixel("blink_f4", 16'h0002, 1'b0, 1'b1, 1);

    // Race: write held across startOfFrame lands on the following commit
    do_reset();
    @(negedge clk);
    cfgLayer = 4'd0; cfgRank = 4'd0; cfgEnable = 1'b0; cfgBlink = 1'b0;
    cfgValid = 1'b1;
    startOfFrame = 1'b1;
    #1;
    check("race/ready_lo", 32'(cfgReady), 32'd0);
    @(negedge clk);
    startOfFrame = 1'b0;
    #1;
    check("race/ready_hi", 32'(cfgReady), 32'd1);
    @(negedge clk);
    cfgValid = 1'b0;
    run_pixel("race_pre", 16'h0021, 1'b0, 1'b1, 0);
    run_pixel("race_commit", 16'h0000, 1'b1, 1'b0, 0);
    run_pixel("race_post", 16'h0021, 1'b0, 1'b1, 5);

    // Collision summary
    do_reset();
    run_pixel("coll_n", 16'h0090, 1'b0, 1'b1, 4);
    run_pixel("coll_sof1", 16'h0003, 1'b1, 1'b1, 0);
`ifdef LAYER_MUX_COLLISION_EN
    check("coll/flags_90", 32'(collisionFlags), 32'h0090);
`else
    check("coll/flags_off", 32'(collisionFlags), 32'h0000);
`endif
    run_pixel("coll_free", 16'h0010, 1'b0, 1'b1, 4);
    run_pixel("coll_sof2", 16'h0000, 1'b1, 1'b0, 0);
`ifdef LAYER_MUX_COLLISION_EN
    check("coll/flags_03", 32'(collisionFlags), 32'h0003);
`else
    check("coll/flags_off2", 32'(collisionFlags), 32'h0000);
`endif
    run_pixel("coll_sof3", 16'h0000, 1'b1, 1'b0, 0);
    check("coll/flags_clr", 32'(collisionFlags), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
